// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction fetch stage
package fetch_pkg;

    typedef enum logic {
        FS_RUN  = 1'b0,
        FS_HALT = 1'b1
    } fetch_state_t;

    localparam logic [31:0] PC_STEP        = 32'd4;
    localparam logic [31:0] PC_READ_OFFSET = 32'd8;
    localparam logic [31:0] HALT_WORD      = 32'h0000_0000;

endpackage

// File: rtl/fetch_pc_reg.sv
// rtl/fetch_pc_reg.sv - program counter register with redirect/step/hold next-PC mux
module fetch_pc_reg
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        advance,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] pc
);

    // Byte-offset bits of the branch target are dropped; targets are word aligned.
    logic unused_offset_bits;
    assign unused_offset_bits = ^redirect_pc[1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= RESET_PC;
        end else if (redirect_valid) begin
            pc <= {redirect_pc[31:2], 2'b00};
        end else if (advance) begin
            pc <= pc + PC_STEP;
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - fetch stage top: FSM and output register; FETCH_HALT_ON_ZERO_EN enables halt on zero word
module instr_fetch
    import fetch_pkg::*;
#(
    parameter int          ADDR_BITS  = 8,
    parameter int          DATA_WIDTH = 32,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic [ADDR_BITS-1:0]  rom_addr,
    input  logic [DATA_WIDTH-1:0] rom_data,
    input  logic                  redirect_valid,
    input  logic [31:0]           redirect_pc,
    output logic                  if_valid,
    input  logic                  if_ready,
    output logic [DATA_WIDTH-1:0] if_instr,
    output logic [31:0]           if_pc,
    output logic [31:0]           if_pc_plus8,
    output logic                  halted
);

    fetch_state_t state_q;
    fetch_state_t state_d;
    logic [31:0]  pc;
    logic         can_load;
    logic         load;
    logic         halt_hit;
    logic         zero_word;

    fetch_pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk            (clk),
        .rst_n          (rst_n),
        .advance        (load),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .pc             (pc)
    );

    assign rom_addr    = pc[ADDR_BITS+1:2];
    assign if_pc_plus8 = if_pc + PC_READ_OFFSET;
    assign can_load    = (state_q == FS_RUN) && (!if_valid || if_ready);

`ifdef FETCH_HALT_ON_ZERO_EN
    assign zero_word = (rom_data == DATA_WIDTH'(HALT_WORD));
    assign halted    = (state_q == FS_HALT);
`else
    assign zero_word = 1'b0;
    assign halted    = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FS_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Redirect outranks everything, including halt entry on the same cycle.
    always_comb begin
        state_d  = state_q;
        load     = 1'b0;
        halt_hit = 1'b0;
        if (redirect_valid) begin
            state_d = FS_RUN;
        end else if (can_load) begin
            if (zero_word) begin
                halt_hit = 1'b1;
                state_d  = FS_HALT;
            end else begin
                load = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if_valid <= 1'b0;
            if_instr <= '0;
            if_pc    <= '0;
        end else if (redirect_valid) begin
            if_valid <= 1'b0;
        end else if (load) begin
            if_valid <= 1'b1;
            if_instr <= rom_data;
            if_pc    <= pc;
        end else if (halt_hit) begin
            if_valid <= 1'b0;
        end else if ((state_q == FS_HALT) && if_ready) begin
            if_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - randomized self-checking bench for instr_fetch against a behavioural model
module tb_instr_fetch;

`ifdef FETCH_HALT_ON_ZERO_EN
    localparam bit HALT_EN = 1'b1;
`else
    localparam bit HALT_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  rom_addr;
    logic [31:0] rom_data;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        if_valid;
    logic        if_ready = 1'b0;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [31:0] if_pc_plus8;
    logic        halted;

    logic [31:0] rom [256];
    assign rom_data = rom[rom_addr];

    always #5 clk = ~clk;

    instr_fetch dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .rom_addr       (rom_addr),
        .rom_data       (rom_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .if_pc_plus8    (if_pc_plus8),
        .halted         (halted)
    );

    int checks = 0;
    int errors = 0;

    // Reference state: what the stage should be presenting, by the fetch rules.
    logic [31:0] m_pc;
    logic        m_valid;
    logic [31:0] m_instr;
    logic [31:0] m_if_pc;
    logic        m_halt;
    int          obs_cons = 0;
    int          exp_cons = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc    = 32'h0;
        m_valid = 1'b0;
        m_instr = 32'h0;
        m_if_pc = 32'h0;
        m_halt  = 1'b0;
    endtask

    task automatic model_clock(input logic rv, input logic [31:0] rpc, input logic rdy);
        logic [31:0] w;
        if (rv) begin
            m_pc    = rpc & 32'hFFFF_FFFC;
            m_valid = 1'b0;
            m_halt  = 1'b0;
        end else if (!m_halt && (!m_valid || rdy)) begin
            w = rom[m_pc[9:2]];
            if (HALT_EN && w == 32'h0) begin
                m_valid = 1'b0;
                m_halt  = 1'b1;
            end else begin
                m_instr = w;
                m_if_pc = m_pc;
                m_valid = 1'b1;
                m_pc    = m_pc + 32'd4;
            end
        end else if (m_halt && rdy) begin
            m_valid = 1'b0;
        end
    endtask

    task automatic compare_all();
        check("if_valid", 32'(if_valid), 32'(m_valid));
        check("halted", 32'(halted), 32'(m_halt));
        check("rom_addr", 32'(rom_addr), 32'(m_pc[9:2]));
        if (m_valid) begin
            check("if_instr", if_instr, m_instr);
            check("if_pc", if_pc, m_if_pc);
            check("if_pc_plus8", if_pc_plus8, m_if_pc + 32'd8);
        end
    endtask

    // Called just after a falling edge: drive, clock, then compare mid-cycle.
    task automatic step(input logic rv, input logic [31:0] rpc, input logic rdy);
        redirect_valid = rv;
        redirect_pc    = rpc;
        if_ready       = rdy;
        #1;
        if (if_valid && rdy) obs_cons++;
        if (m_valid && rdy) exp_cons++;
        @(posedge clk);
        model_clock(rv, rpc, rdy);
        @(negedge clk);
        compare_all();
    endtask

    initial begin
        int c0;
        for (int i = 0; i < 256; i++) rom[i] = $urandom | 32'h1;
        rom[0]  = 32'he3a00b01;
        rom[1]  = 32'he3a01c05;
        rom[69] = 32'h0;
        model_reset();

        repeat (2) @(negedge clk);
        check("rst_valid", 32'(if_valid), 32'd0);
        check("rst_pc", if_pc, 32'd0);
        check("rst_instr", if_instr, 32'd0);
        check("rst_plus8", if_pc_plus8, 32'd8);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_rom_addr", 32'(rom_addr), 32'd0);
        rst_n = 1'b1;

        step(1'b0, 32'h0, 1'b1);
        check("first_instr", if_instr, 32'he3a00b01);
        check("first_pc", if_pc, 32'h0);
        check("first_plus8", if_pc_plus8, 32'h8);
        step(1'b0, 32'h0, 1'b1);
        check("second_instr", if_instr, 32'he3a01c05);
        check("second_pc", if_pc, 32'h4);
        step(1'b0, 32'h0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 32'h0, 1'b0);
            check("stall_pc", if_pc, 32'h8);
            check("stall_instr", if_instr, rom[2]);
            check("stall_rom_addr", 32'(rom_addr), 32'd3);
        end
        step(1'b0, 32'h0, 1'b1);
        check("release_pc", if_pc, 32'hC);

        step(1'b1, 32'h0000_00A3, 1'b0);
        check("redir_bubble", 32'(if_valid), 32'd0);
        check("redir_rom_addr", 32'(rom_addr), 32'd40);
        step(1'b0, 32'h0, 1'b1);
        check("redir_pc", if_pc, 32'hA0);
        check("redir_valid", 32'(if_valid), 32'd1);

        c0 = obs_cons;
        step(1'b1, 32'h0000_0040, 1'b1);
        check("redir_hs_count", 32'(obs_cons - c0), 32'd1);
        step(1'b0, 32'h0, 1'b1);
        check("redir_hs_pc", if_pc, 32'h40);

        step(1'b1, 32'h0000_0100, 1'b1);
        repeat (5) step(1'b0, 32'h0, 1'b1);
        check("pre_zero_pc", if_pc, 32'h110);
        step(1'b0, 32'h0, 1'b1);
        if (HALT_EN) begin
            for (int i = 0; i < 3; i++) begin
                check("halt_flag", 32'(halted), 32'd1);
                check("halt_valid", 32'(if_valid), 32'd0);
                step(1'b0, 32'h0, 1'b1);
            end
            step(1'b1, 32'h0000_0080, 1'b1);
            check("unhalt_flag", 32'(halted), 32'd0);
            step(1'b0, 32'h0, 1'b1);
            check("unhalt_pc", if_pc, 32'h80);
        end else begin
            check("zero_pc", if_pc, 32'h114);
            check("zero_instr", if_instr, 32'h0);
            step(1'b0, 32'h0, 1'b1);
            check("after_zero_pc", if_pc, 32'h118);
        end

        step(1'b1, 32'hFFFF_FFFE, 1'b1);
        step(1'b0, 32'h0, 1'b1);
        check("wrap_pc", if_pc, 32'hFFFF_FFFC);
        check("wrap_plus8", if_pc_plus8, 32'h4);
        step(1'b0, 32'h0, 1'b1);
        check("wrap_next_pc", if_pc, 32'h0);

        for (int i = 0; i < 600; i++) begin
            logic        rv;
            logic [31:0] rpc;
            rv  = ($urandom_range(0, 9) == 0);
            rpc = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 1023));
            step(rv, rpc, ($urandom_range(0, 9) < 7));
        end
        check("consumed_count", 32'(obs_cons), 32'(exp_cons));

        step(1'b1, 32'h0, 1'b1);
        step(1'b0, 32'h0, 1'b1);
        check("pre_async_valid", 32'(if_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async_valid", 32'(if_valid), 32'd0);
        check("async_pc", if_pc, 32'd0);
        check("async_rom_addr", 32'(rom_addr), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
